// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code decoder: prefix bytes, decoder
// states and the packed event word carried through the event FIFO.
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    // The Pause key sends E1 followed by seven more bytes that carry no key info.
    localparam logic [2:0] PS2_PAUSE_TAIL = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous FIFO of decoded key events with a combinational head view,
// so the head event is presented in the same cycle the FIFO becomes non-empty.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  ps2_event_t             i_push_data,
    input  logic                   i_pop,
    output ps2_event_t             o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    ps2_event_t        r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_pop;
    logic              w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_FULL);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a push while full is still accepted.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (AW + 1)'(1);
            end
        end
    end

    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: folds E0/F0/E1 prefixes into key events and
// queues them in a FIFO. Define PS2_DEC_ERRCNT_EN to add the err_cnt output.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int CLK_MHZ    = 50,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  ps2_code,
    input  logic                        ps2_code_new,
    input  logic                        valid,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [7:0]                  ev_code,
    output logic                        ev_ext,
    output logic                        ev_break,
    output logic [$clog2(FIFO_DEPTH):0] ev_count,
    output logic                        overflow
`ifdef PS2_DEC_ERRCNT_EN
    ,
    output logic [7:0]                  err_cnt
`endif
);

    localparam int TMO_CYCLES = TIMEOUT_US * CLK_MHZ;
    localparam int TW         = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);

    ps2_state_e  r_state;
    ps2_state_e  w_state_next;
    logic [2:0]  r_skip;
    logic [2:0]  w_skip_next;
    logic [TW-1:0] r_tmo;
    logic        r_overflow;
    logic        w_push;
    ps2_event_t  w_push_ev;
    logic        w_timeout;
    logic        w_bad_strobe;
    logic        w_pop;
    logic        w_drop;
    logic        w_full;
    logic        w_empty;
    ps2_event_t  w_head;

    always_comb begin
        w_state_next = r_state;
        w_skip_next  = r_skip;
        w_push       = 1'b0;
        w_push_ev    = '0;
        w_timeout    = 1'b0;
        w_bad_strobe = 1'b0;
        if (ps2_code_new && !valid) begin
            w_bad_strobe = 1'b1;
            w_state_next = IDLE;
        end else if (ps2_code_new) begin
            w_push_ev.code = ps2_code;
            case (r_state)
                IDLE: begin
                    if (ps2_code == PS2_PFX_EXT) begin
                        w_state_next = EXT;
                    end else if (ps2_code == PS2_PFX_BRK) begin
                        w_state_next = BRK;
                    end else if (ps2_code == PS2_PFX_PAUSE) begin
                        w_state_next = SKIP;
                        w_skip_next  = PS2_PAUSE_TAIL;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                EXT: begin
                    if (ps2_code == PS2_PFX_BRK) begin
                        w_state_next = EXT_BRK;
                    end else begin
                        w_push        = 1'b1;
                        w_push_ev.ext = 1'b1;
                        w_state_next  = IDLE;
                    end
                end
                BRK: begin
                    w_push        = 1'b1;
                    w_push_ev.brk = 1'b1;
                    w_state_next  = IDLE;
                end
                EXT_BRK: begin
                    w_push        = 1'b1;
                    w_push_ev.ext = 1'b1;
                    w_push_ev.brk = 1'b1;
                    w_state_next  = IDLE;
                end
                SKIP: begin
                    // The whole Pause sequence collapses into a single E1 event on its last byte.
                    if (r_skip == 3'd1) begin
                        w_push         = 1'b1;
                        w_push_ev.ext  = 1'b1;
                        w_push_ev.code = PS2_PFX_PAUSE;
                        w_state_next   = IDLE;
                    end else begin
                        w_skip_next = r_skip - 3'd1;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end else if (r_state != IDLE && r_tmo == TMO_LAST) begin
            w_timeout    = 1'b1;
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_skip  <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_next;
            r_skip  <= w_skip_next;
            if (ps2_code_new || r_state == IDLE) begin
                r_tmo <= '0;
            end else if (r_tmo != TMO_LAST) begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

    assign w_pop  = ev_valid && ev_ready;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef PS2_DEC_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if ((w_bad_strobe || w_timeout || w_drop) && r_err_cnt != 8'hFF) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_data(w_push_ev),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (ev_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign ev_valid = !w_empty;
    assign ev_code  = w_head.code;
    assign ev_ext   = w_head.ext;
    assign ev_break = w_head.brk;
    assign overflow = r_overflow;

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter CLK_MHZ, default 50, system clock frequency in MHz.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter TIMEOUT_US, default 2000, maximum gap between bytes of one multi-byte sequence.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port ps2_code, input, 8, received byte from the upstream PS/2 receiver.
REQ-007 SHALL have port ps2_code_new, input, 1, one-cycle strobe: ps2_code holds a new byte.
REQ-008 SHALL have port valid, input, 1, frame/parity good for the strobed byte; sampled only with ps2_code_new.
REQ-009 SHALL have port ev_valid, output, 1, head FIFO event available.
REQ-010 SHALL have port ev_ready, input, 1, consumer accepts the event.
REQ-011 SHALL have port ev_code, output, 8, key scan code of the head event.
REQ-012 SHALL have port ev_ext, output, 1, head event carried the E0 or E1 prefix.
REQ-013 SHALL have port ev_break, output, 1, head event is a release (F0 seen).
REQ-014 SHALL have port ev_count, output, clog2(FIFO_DEPTH)+1, FIFO occupancy.
REQ-015 SHALL have port overflow, output, 1, sticky: an event was dropped because the FIFO was full.

Function
REQ-016 SHALL implement states IDLE, EXT, BRK, EXT_BRK, SKIP; bytes are consumed only on ps2_code_new=1 with valid=1.
REQ-017 SHALL handle bytes in IDLE: E0 -> EXT; F0 -> BRK; E1 -> SKIP with skip counter=7; any other byte -> push {ext=0, brk=0, code}.
REQ-018 SHALL handle bytes in EXT: F0 -> EXT_BRK; other -> push {1,0,code}, go to IDLE.
REQ-019 SHALL handle bytes in BRK: push {0,1,code}, go to IDLE. In EXT_BRK: push {1,1,code}, go to IDLE.
REQ-020 SHALL, in SKIP, decrement the counter per byte; at the 7th byte push {ext=1, brk=0, code=8'hE1} and go to IDLE.
REQ-021 SHALL, on a strobe with valid=0, discard the byte and go to IDLE from any state; nothing is pushed.
REQ-022 SHALL, when in any state other than IDLE for TIMEOUT_US*CLK_MHZ cycles without a strobe, go to IDLE without pushing; the timeout counter restarts on every strobe.
REQ-023 SHALL register the push: ev_valid rises in the cycle after the strobe that completes an event, when the FIFO was empty.
REQ-024 SHALL pop on ev_valid && ev_ready; ev_code, ev_ext and ev_break stay stable while ev_valid=1 and ev_ready=0.
REQ-025 SHALL, on a push while full with no pop in the same cycle, drop the new event, leave the contents unchanged and set overflow.
REQ-026 SHALL, on a push and a pop in the same cycle while full, accept the push; ev_count is unchanged and overflow is not set.
REQ-027 SHALL wrap the FIFO pointers modulo FIFO_DEPTH; ev_count never exceeds FIFO_DEPTH.

Reset
REQ-028 SHALL, on rst, set state=IDLE, clear the counters and the FIFO, and drive ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, ev_count=0, overflow=0.
REQ-029 SHALL let rst take priority over a same-cycle strobe or pop; a sequence in progress is abandoned.

Configuration
REQ-030 SHALL, with macro PS2_DEC_ERRCNT_EN defined, add output err_cnt, 8 bits: counts valid=0 strobes, timeouts and dropped events, saturates at 255, cleared by rst.
REQ-031 SHALL, without PS2_DEC_ERRCNT_EN, have no err_cnt port and no counter logic.

Structure
REQ-032 SHALL place in package ps2_pkg: the constants PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0 and PS2_PFX_PAUSE=8'hE1; the state enum; and the packed typedef ps2_event_t {ext, brk, code[7:0]}.
REQ-033 SHALL implement the event buffer as sub-module ps2_event_fifo, a synchronous FIFO of ps2_event_t.

Verification
REQ-034 SHALL cover: strobe 1C -> one event {0,0,1C}, ev_valid one cycle later.
REQ-035 SHALL cover: strobes E0,F0,74 -> one event {1,1,74}; no event after E0 or after F0.
REQ-036 SHALL cover: E1,14,77,E1,F0,14,F0,77 -> exactly one event {1,0,E1}.
REQ-037 SHALL cover: ev_ready=0 with FIFO_DEPTH+1 make codes -> ev_count=8, overflow=1, first 8 codes popped in order.
REQ-038 SHALL cover: F0 then no strobe for the timeout, then 1C -> event {0,0,1C}, not a break.
REQ-039 SHALL cover: E0 then a strobe with valid=0, then 75 -> event {0,0,75}; err_cnt=1 when PS2_DEC_ERRCNT_EN is defined.
